// File: rtl/apb_timer.sv
// 32-bit down-counting APB timer with external tick input, one-shot mode and level interrupt.
// Define APB_TIMER_PSLVERR_EN to add PREADY/PSLVERR and error responses for bad addresses.
module apb_timer #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 EXTIN,
`ifdef APB_TIMER_PSLVERR_EN
  output logic                 PREADY,
  output logic                 PSLVERR,
`endif
  output logic                 TIMERINT
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_VALUE   = 2'd1,
    REG_RELOAD  = 2'd2,
    REG_INTSTAT = 2'd3
  } reg_sel_e;

  logic [3:0]           ctrl;
  logic [DATAWIDTH-1:0] value;
  logic [DATAWIDTH-1:0] reload;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 irq_pend;
  logic                 ext_sync1;
  logic                 ext_sync2;
  logic                 ext_prev;
  logic                 addr_ok;
  logic                 wr_en;
  logic                 wr_ctrl;
  logic                 wr_value;
  logic                 wr_reload;
  logic                 wr_intstat;
  logic                 rd_setup;
  logic                 ext_tick;
  logic                 tick;
  logic                 fire;
  reg_sel_e             reg_sel;

  assign reg_sel = reg_sel_e'(PADDR[3:2]);

`ifdef APB_TIMER_PSLVERR_EN
  assign addr_ok = (PADDR[ADDRWIDTH-1:4] == '0) && (PADDR[1:0] == 2'b00);
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~addr_ok;
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^PADDR[1:0];
  assign addr_ok = (PADDR[ADDRWIDTH-1:4] == '0);
`endif

  assign wr_en      = PSEL & PENABLE & PWRITE & addr_ok;
  assign wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
  assign wr_value   = wr_en && (reg_sel == REG_VALUE);
  assign wr_reload  = wr_en && (reg_sel == REG_RELOAD);
  assign wr_intstat = wr_en && (reg_sel == REG_INTSTAT);
  assign rd_setup   = PSEL & ~PENABLE & ~PWRITE;

  // A CTRL write that clears EN takes effect on the same edge, suppressing that tick.
  assign ext_tick = ext_sync2 & ~ext_prev;
  assign tick     = ctrl[0] & (ctrl[2] ? ext_tick : 1'b1) & ~(wr_ctrl & ~PWDATA[0]);
  assign fire     = tick & ~wr_value & (value == DATAWIDTH'(1));

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      case (reg_sel)
        REG_CTRL:    rd_data = {{(DATAWIDTH-4){1'b0}}, ctrl};
        REG_VALUE:   rd_data = value;
        REG_RELOAD:  rd_data = reload;
        REG_INTSTAT: rd_data = {{(DATAWIDTH-1){1'b0}}, irq_pend};
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl      <= '0;
      value     <= '0;
      reload    <= '0;
      irq_pend  <= 1'b0;
      PRDATA    <= '0;
      ext_sync1 <= 1'b0;
      ext_sync2 <= 1'b0;
      ext_prev  <= 1'b0;
    end else begin
      ext_sync1 <= EXTIN;
      ext_sync2 <= ext_sync1;
      ext_prev  <= ext_sync2;

      // Read data is captured in the setup phase and dropped after the access edge.
      PRDATA <= rd_setup ? rd_data : '0;

      if (wr_ctrl)
        ctrl <= PWDATA[3:0];
      else if (fire && ctrl[3])
        ctrl[0] <= 1'b0;

      if (wr_reload)
        reload <= PWDATA;

      if (wr_value)
        value <= PWDATA;
      else if (tick) begin
        if (value == DATAWIDTH'(1))
          value <= ctrl[3] ? '0 : reload;
        else if (value == '0)
          value <= reload;
        else
          value <= value - DATAWIDTH'(1);
      end

      if (fire)
        irq_pend <= 1'b1;
      else if (wr_intstat && PWDATA[0])
        irq_pend <= 1'b0;
    end
  end

  assign TIMERINT = irq_pend & ctrl[1];

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: a register-level model is stepped every clock and
// compared against TIMERINT/PRDATA each cycle, with directed scenarios pinned by literal values.
module tb_apb_timer;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        EXTIN;
  logic        TIMERINT;
`ifdef APB_TIMER_PSLVERR_EN
  logic        PREADY;
  logic        PSLVERR;
`endif

  int checks;
  int errors;

  logic [3:0]  m_ctrl;
  logic [31:0] m_value;
  logic [31:0] m_reload;
  logic [31:0] m_prdata;
  logic        m_irq;
  logic [2:0]  ext_hist;

  apb_timer #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .EXTIN    (EXTIN),
`ifdef APB_TIMER_PSLVERR_EN
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
`endif
    .TIMERINT (TIMERINT)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic model_hit();
`ifdef APB_TIMER_PSLVERR_EN
    return (PADDR[15:4] == 12'd0) && (PADDR[1:0] == 2'd0);
`else
    return (PADDR[15:4] == 12'd0);
`endif
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_value;
      2'd2:    return m_reload;
      default: return {31'd0, m_irq};
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // External ticks are derived from the sampled EXTIN history: a tick lands on the
  // edge two samples after the first high sample of a rise.
  task automatic model_edge();
    logic       hit, rd, wr, ext, tick, fire;
    logic [1:0] idx;
    if (PRESET) begin
      m_ctrl   = '0;
      m_value  = '0;
      m_reload = '0;
      m_irq    = 1'b0;
      m_prdata = '0;
      ext_hist = '0;
    end else begin
      hit  = model_hit();
      idx  = PADDR[3:2];
      rd   = PSEL && !PENABLE && !PWRITE;
      wr   = PSEL && PENABLE && PWRITE && hit;
      ext  = ext_hist[1] && !ext_hist[2];
      tick = m_ctrl[0] && (!m_ctrl[2] || ext) && !(wr && idx == 2'd0 && !PWDATA[0]);
      fire = tick && !(wr && idx == 2'd1) && (m_value == 32'd1);
      m_prdata = (rd && hit) ? model_reg(idx) : 32'd0;
      ext_hist = {ext_hist[1:0], EXTIN};
      if (wr && idx == 2'd1) m_value = PWDATA;
      else if (tick) begin
        if (m_value == 32'd1)      m_value = m_ctrl[3] ? 32'd0 : m_reload;
        else if (m_value == 32'd0) m_value = m_reload;
        else                       m_value = m_value - 32'd1;
      end
      if (wr && idx == 2'd2) m_reload = PWDATA;
      if (fire) m_irq = 1'b1;
      else if (wr && idx == 2'd3 && PWDATA[0]) m_irq = 1'b0;
      if (wr && idx == 2'd0) m_ctrl = PWDATA[3:0];
      else if (fire && m_ctrl[3]) m_ctrl[0] = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check_output("cyc_timerint", {31'd0, TIMERINT}, {31'd0, m_irq & m_ctrl[1]});
    check_output("cyc_prdata", PRDATA, m_prdata);
`ifdef APB_TIMER_PSLVERR_EN
    check_output("cyc_pslverr", {31'd0, PSLVERR}, {31'd0, PSEL & PENABLE & !model_hit()});
    check_output("cyc_pready", {31'd0, PREADY}, 32'd1);
`endif
  endtask

  task automatic apply_stimulus(input logic sel, input logic enable, input logic write,
                                input logic [15:0] addr, input logic [31:0] data);
    PSEL    = sel;
    PENABLE = enable;
    PWRITE  = write;
    PADDR   = addr;
    PWDATA  = data;
    @(posedge PCLK);
    model_edge();
    @(negedge PCLK);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, 1'b0, 1'b1, addr, data);
    apply_stimulus(1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] data);
    apply_stimulus(1'b1, 1'b0, 1'b0, addr, 32'h0);
    data = PRDATA;
    apply_stimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic read_expect(input string name, input logic [15:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    apb_read(addr, rd);
    check_output(name, rd, expected);
  endtask

  initial begin
    int first_rise;
    int rises;
    logic prev_int;
    logic [31:0] rd;

    checks = 0;
    errors = 0;
    PCLK = 1'b0;
    PRESET = 1'b1;
    EXTIN = 1'b0;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = '0;
    PWDATA = '0;
    m_ctrl = '0;
    m_value = '0;
    m_reload = '0;
    m_irq = 1'b0;
    m_prdata = '0;
    ext_hist = '0;

    $display("[TB] reset");
    idle(2);
    PRESET = 1'b0;
    read_expect("rst_ctrl", 16'h0, 32'h0);
    read_expect("rst_value", 16'h4, 32'h0);
    read_expect("rst_reload", 16'h8, 32'h0);
    read_expect("rst_intstat", 16'hC, 32'h0);
    check_output("rst_timerint", {31'd0, TIMERINT}, 32'd0);

    $display("[TB] periodic count");
    apb_write(16'h8, 32'd5);
    apb_write(16'h4, 32'd5);
    apb_write(16'h0, 32'h3);
    first_rise = 0;
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      if (TIMERINT && first_rise == 0) first_rise = i;
    end
    check_output("period_first_irq", first_rise, 32'd5);
    check_output("model_value_reloaded", m_value, 32'd5);
    read_expect("period_intstat", 16'hC, 32'd1);
    apb_write(16'hC, 32'd1);
    check_output("w1c_timerint_low", {31'd0, TIMERINT}, 32'd0);
    idle(1);
    check_output("period_second_irq", {31'd0, TIMERINT}, 32'd1);
    apb_write(16'h0, 32'h0);
    read_expect("en_clear_no_dec", 16'h4, 32'd4);
    apb_write(16'hC, 32'd1);
    check_output("period_cleared", {31'd0, TIMERINT}, 32'd0);

    $display("[TB] one-shot");
    apb_write(16'h8, 32'd3);
    apb_write(16'h4, 32'd3);
    apb_write(16'h0, 32'hB);
    rises = 0;
    prev_int = TIMERINT;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (TIMERINT && !prev_int) rises++;
      prev_int = TIMERINT;
    end
    check_output("oneshot_rises", rises, 32'd1);
    check_output("model_oneshot_ctrl", {28'd0, m_ctrl}, 32'hA);
    read_expect("oneshot_value", 16'h4, 32'd0);
    read_expect("oneshot_ctrl", 16'h0, 32'hA);
    apb_write(16'hC, 32'd1);
    idle(3);

    $display("[TB] external tick");
    apb_write(16'h0, 32'h5);
    apb_write(16'h4, 32'd4);
    EXTIN = 1'b1;
    idle(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h4, 32'h0);
    rd = PRDATA;
    EXTIN = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h4, 32'h0);
    check_output("ext_no_early_dec", rd, 32'd4);
    for (int p = 2; p <= 4; p++) begin
      EXTIN = 1'b1;
      idle(3);
      EXTIN = 1'b0;
      apb_read(16'h4, rd);
      check_output("ext_dec_on_time", rd, (p == 4) ? 32'd3 : 32'(4 - p));
    end
    check_output("model_ext_irq", {31'd0, m_irq}, 32'd1);
    read_expect("ext_intstat", 16'hC, 32'd1);
    check_output("ext_timerint_masked", {31'd0, TIMERINT}, 32'd0);

    $display("[TB] collisions");
    apb_write(16'h0, 32'h0);
    apb_write(16'hC, 32'd1);
    apb_write(16'h8, 32'd4);
    apb_write(16'h4, 32'd4);
    apb_write(16'h0, 32'h1);
    idle(2);
    apb_write(16'hC, 32'd1);
    read_expect("set_beats_w1c", 16'hC, 32'd1);
    apb_write(16'h4, 32'h100);
    read_expect("write_beats_tick", 16'h4, 32'h100);
    apb_write(16'h0, 32'h0);

    $display("[TB] reset mid-count");
    apb_write(16'h8, 32'd2);
    apb_write(16'h4, 32'd2);
    apb_write(16'h0, 32'h3);
    PRESET = 1'b1;
    idle(1);
    PRESET = 1'b0;
    idle(3);
    check_output("midrst_timerint", {31'd0, TIMERINT}, 32'd0);
    read_expect("midrst_value", 16'h4, 32'd0);
    read_expect("midrst_intstat", 16'hC, 32'd0);

    $display("[TB] unmapped access");
    apb_write(16'h10, 32'hF);
    read_expect("unmapped_ctrl_kept", 16'h0, 32'h0);
    read_expect("unmapped_read", 16'h10, 32'h0);
`ifdef APB_TIMER_PSLVERR_EN
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h10, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h10, 32'h0);
    check_output("slverr_read", {31'd0, PSLVERR}, 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'h6, 32'h55);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h6, 32'h55);
    check_output("slverr_write", {31'd0, PSLVERR}, 32'd1);
    read_expect("slverr_value_kept", 16'h4, 32'h0);
    check_output("slverr_mapped", {31'd0, PSLVERR}, 32'd0);
`endif
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
